fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage. Holds the fetch PC and runs a single-outstanding request/valid handshake with instruction memory. Buffers one returned word when decode is stalled and delivers `{instruction, PC+4}` to decode. Accepts the decode stage's resolved next-PC (branch, jump, `jr`) as a redirect that squashes wrong-path fetches.

---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem handshake, one-word stall buffer, IF/ID register.
// Define FETCH_ALIGN_CHECK_EN to add the sticky o_MisalignF flag for unaligned redirect targets.
module fetch_stage #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_StallD,
    input  logic                     i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
    output logic                     o_IMemReq,
    output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
    input  logic                     i_IMemValid,
    input  logic [INSTR_WIDTH-1:0]   i_IMemRdata,
    output logic [INSTR_WIDTH-1:0]   o_InstrD,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
    output logic                     o_ValidD
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                     o_MisalignF
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK  = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDRESS_WIDTH-1:0] WORD_BYTES = ADDRESS_WIDTH'(4);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pcf_q, pcf_d;
    logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                     hold_v_q, hold_v_d;
    logic [INSTR_WIDTH-1:0]   hold_instr_q, hold_instr_d;
    logic [ADDRESS_WIDTH-1:0] hold_pc4_q, hold_pc4_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] pc4_q, pc4_d;
    logic                     valid_q, valid_d;

    logic                     redirect;
    logic                     resp;
    logic                     avail;
    logic [ADDRESS_WIDTH-1:0] req_pc4;
    logic [ADDRESS_WIDTH-1:0] target;

    // A stalled decode stage cannot have resolved its branch, so its redirect is not trusted.
    assign redirect = i_PCSrcD & ~i_StallD;
    assign resp     = (state_q == S_REQ) & i_IMemValid;
    assign avail    = hold_v_q | resp;
    assign req_pc4  = req_addr_q + WORD_BYTES;
    assign target   = i_PCNextD & WORD_MASK;

    assign o_IMemReq  = ~i_RST & (state_q != S_IDLE);
    assign o_IMemAddr = req_addr_q;
    assign o_InstrD   = instr_q;
    assign o_PCPlus4D = pc4_q;
    assign o_ValidD   = valid_q;

    // IF/ID, hold buffer and PC next-state
    always_comb begin
        hold_v_d     = hold_v_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        pcf_d        = pcf_q;

        if (!i_StallD) begin
            hold_v_d = 1'b0;
            instr_d  = '0;
            valid_d  = 1'b0;
            if (!redirect && avail) begin
                valid_d = 1'b1;
                if (hold_v_q) begin
                    instr_d = hold_instr_q;
                    pc4_d   = hold_pc4_q;
                end else begin
                    instr_d = i_IMemRdata;
                    pc4_d   = req_pc4;
                end
            end
        end else if (resp) begin
            hold_v_d     = 1'b1;
            hold_instr_d = i_IMemRdata;
            hold_pc4_d   = req_pc4;
        end

        if (redirect) begin
            pcf_d = target;
        end else if (resp) begin
            pcf_d = req_pc4;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        case (state_q)
            S_IDLE: begin
                if (!hold_v_d) begin
                    state_d    = S_REQ;
                    req_addr_d = pcf_d;
                end
            end
            S_REQ: begin
                if (i_IMemValid) begin
                    if (i_StallD) begin
                        state_d = S_IDLE;
                    end else begin
                        req_addr_d = pcf_d;
                    end
                end else if (redirect) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (i_IMemValid) begin
                    state_d    = S_REQ;
                    req_addr_d = pcf_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= S_IDLE;
            pcf_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_v_q   <= 1'b0;
            instr_q    <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            req_addr_q <= req_addr_d;
            hold_v_q   <= hold_v_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

    // Buffer payload is qualified by hold_v_q, so it needs no reset.
    always_ff @(posedge i_CLK) begin
        hold_instr_q <= hold_instr_d;
        hold_pc4_q   <= hold_pc4_d;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;
    assign o_MisalignF = misalign_q;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            misalign_q <= 1'b0;
        end else if (redirect && (i_PCNextD[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences, and
// randomized traffic against a transaction-level reference model with a latency-programmable memory.
module tb_fetch_stage;

    logic        clk;
    logic        i_RST;
    logic        i_StallD;
    logic        i_PCSrcD;
    logic [31:0] i_PCNextD;
    logic        o_IMemReq;
    logic [31:0] o_IMemAddr;
    logic        i_IMemValid;
    logic [31:0] i_IMemRdata;
    logic [31:0] o_InstrD;
    logic [31:0] o_PCPlus4D;
    logic        o_ValidD;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        o_MisalignF;
`endif

    fetch_stage #(
        .ADDRESS_WIDTH(32),
        .INSTR_WIDTH  (32),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .i_CLK      (clk),
        .i_RST      (i_RST),
        .i_StallD   (i_StallD),
        .i_PCSrcD   (i_PCSrcD),
        .i_PCNextD  (i_PCNextD),
        .o_IMemReq  (o_IMemReq),
        .o_IMemAddr (o_IMemAddr),
        .i_IMemValid(i_IMemValid),
        .i_IMemRdata(i_IMemRdata),
        .o_InstrD   (o_InstrD),
        .o_PCPlus4D (o_PCPlus4D),
        .o_ValidD   (o_ValidD)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .o_MisalignF(o_MisalignF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: fetch slot, wrong-path marker, queue-based stall buffer, IF/ID contents.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } word_t;

    word_t       m_hold[$];
    logic [31:0] m_pc, m_addr, m_instr, m_pc4;
    logic        m_out, m_wrong, m_vld, m_mis;

    // Memory responder: answers the model's outstanding request after mem_lat waiting cycles.
    int  mem_cnt = 0;
    int  mem_lat = 0;
    bit  mem_fixed = 1'b1;
    int  mem_fix_lat = 0;

    logic        s_req, s_vld, s_mis;
    logic [31:0] s_addr, s_instr, s_pc4;

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_out = 1'b0; m_wrong = 1'b0;
        m_hold.delete();
        m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0; m_mis = 1'b0;
    endtask

    task automatic cycle(input logic rst, input logic stall, input logic src, input logic [31:0] nxt);
        logic  exp_req, mvalid, eff, got;
        logic [31:0] newpc;
        word_t w;
        i_RST     = rst;
        i_StallD  = stall;
        i_PCSrcD  = src;
        i_PCNextD = nxt;
        exp_req   = m_out && !rst;
        mvalid    = exp_req && (mem_cnt >= mem_lat);
        i_IMemValid = mvalid;
        i_IMemRdata = mvalid ? tag(m_addr) : $urandom;
        #1;
        s_req = o_IMemReq; s_addr = o_IMemAddr; s_instr = o_InstrD; s_pc4 = o_PCPlus4D; s_vld = o_ValidD;
`ifdef FETCH_ALIGN_CHECK_EN
        s_mis = o_MisalignF;
        chk("model_misalign", {31'b0, s_mis}, {31'b0, m_mis});
`else
        s_mis = 1'b0;
`endif
        chk("model_req", {31'b0, s_req}, {31'b0, exp_req});
        if (exp_req) chk("model_addr", s_addr, m_addr);
        chk("model_instr", s_instr, m_instr);
        chk("model_pc4", s_pc4, m_pc4);
        chk("model_vld", {31'b0, s_vld}, {31'b0, m_vld});

        if (rst) begin
            model_reset();
        end else begin
            eff = src && !stall;
            got = m_out && !m_wrong && mvalid;
            if (m_hold.size() > 0) w = m_hold[0];
            else begin w.instr = tag(m_addr); w.pc4 = m_addr + 32'd4; end
            if (!stall) begin
                if (!eff && (m_hold.size() > 0 || got)) begin
                    m_instr = w.instr; m_pc4 = w.pc4; m_vld = 1'b1;
                end else begin
                    m_instr = 32'h0; m_vld = 1'b0;
                end
                m_hold.delete();
            end else if (got) begin
                w.instr = tag(m_addr); w.pc4 = m_addr + 32'd4;
                m_hold.push_back(w);
            end
            if (eff && nxt[1:0] != 2'b00) m_mis = 1'b1;
            newpc = eff ? (nxt & 32'hFFFF_FFFC) : (got ? m_addr + 32'd4 : m_pc);
            if (!m_out || mvalid) begin
                m_out = (m_hold.size() == 0);
                m_addr = newpc;
                m_wrong = 1'b0;
            end else if (eff) begin
                m_wrong = 1'b1;
            end
            m_pc = newpc;
        end

        if (rst || !exp_req || mvalid) begin
            mem_cnt = 0;
            if (mvalid) mem_lat = mem_fixed ? mem_fix_lat : int'($urandom_range(0, 3));
        end else begin
            mem_cnt++;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        stall;
        logic        src;
        logic [31:0] nxt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc4;
    } vec_t;

    vec_t vt[16];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        er, ev, src;
        logic [31:0] nx;
        int          r;

        vt[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h4};
        vt[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h8};
        vt[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'hC};
        vt[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h10};
        vt[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10};
        vt[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10};
        vt[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10};
        vt[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h10};
        vt[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h14};
        vt[11] = '{1'b0, 1'b1, 32'h103, 1'b1, 32'h18,  1'b1, 32'h18};
        vt[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h18};
        vt[13] = '{1'b1, 1'b1, 32'h300, 1'b1, 32'h104, 1'b1, 32'h104};
        vt[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h104};
        vt[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h108};

        i_RST = 1'b1; i_StallD = 1'b0; i_PCSrcD = 1'b0; i_PCNextD = 32'h0;
        i_IMemValid = 1'b0; i_IMemRdata = 32'h0;
        model_reset();
        @(negedge clk);

        // Zero-wait stream, stall into the hold buffer, redirects (unaligned, and ignored under stall)
        mem_fixed = 1'b1; mem_fix_lat = 0; mem_lat = 0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, vt[i].stall, vt[i].src, vt[i].nxt);
            chk($sformatf("vec%0d_req", i), {31'b0, s_req}, {31'b0, vt[i].req});
            if (vt[i].req) chk($sformatf("vec%0d_addr", i), s_addr, vt[i].addr);
            chk($sformatf("vec%0d_vld", i), {31'b0, s_vld}, {31'b0, vt[i].vld});
            chk($sformatf("vec%0d_pc4", i), s_pc4, vt[i].pc4);
            chk($sformatf("vec%0d_instr", i), s_instr, vt[i].vld ? tag(vt[i].pc4 - 32'd4) : 32'h0);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_sticky", {31'b0, s_mis}, 32'h1);
`endif

        // Three-cycle memory: each address held 3 cycles, two bubbles between instructions
        mem_fix_lat = 2; mem_lat = 2;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            er = (c >= 1);
            ev = (c >= 4) && ((c - 4) % 3 == 0);
            chk("lat3_req", {31'b0, s_req}, {31'b0, er});
            if (er) chk("lat3_addr", s_addr, 32'((c - 1) / 3 * 4));
            chk("lat3_vld", {31'b0, s_vld}, {31'b0, ev});
            if (ev) chk("lat3_pc4", s_pc4, 32'((c - 1) / 3 * 4));
        end

        // Redirect to 0x200 while 0x40 is outstanding: wrong-path word must be dropped
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c <= 10; c++) begin
            src = (c == 1) || (c == 5);
            nx  = (c == 1) ? 32'h40 : 32'h200;
            cycle(1'b0, 1'b0, src, nx);
            if (c >= 4 && c <= 6) chk("disc_addr40", s_addr, 32'h40);
            if (c == 7) begin
                chk("disc_req200", {31'b0, s_req}, 32'h1);
                chk("disc_addr200", s_addr, 32'h200);
            end
            if (c >= 1 && c <= 9) chk("disc_bubble", {31'b0, s_vld}, 32'h0);
            if (c == 10) begin
                chk("disc_vld", {31'b0, s_vld}, 32'h1);
                chk("disc_pc4", s_pc4, 32'h204);
                chk("disc_instr", s_instr, tag(32'h200));
            end
        end

        // Reset asserted while a request is outstanding
        mem_fix_lat = 1; mem_lat = 1;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c <= 6; c++) begin
            cycle((c == 4), 1'b0, 1'b0, 32'h0);
            if (c == 3) begin
                chk("rst_pre_req", {31'b0, s_req}, 32'h1);
                chk("rst_pre_vld", {31'b0, s_vld}, 32'h1);
            end
            if (c == 4) chk("rst_during_req", {31'b0, s_req}, 32'h0);
            if (c == 5) begin
                chk("rst_after_req", {31'b0, s_req}, 32'h0);
                chk("rst_after_vld", {31'b0, s_vld}, 32'h0);
                chk("rst_after_pc4", s_pc4, 32'h0);
            end
            if (c == 6) chk("rst_refetch_addr", s_addr, 32'h0);
        end

        // Randomized traffic against the reference model
        mem_fixed = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 7));
            nx = (r == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFF);
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), nx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
